pipeline_fetch_ras: RTL

PIPELINE_FETCH_RAS -- requirements
Module: pipeline_fetch_ras

---
 rtl/pipeline_fetch_ras.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipeline_fetch_ras.sv
// rtl/pipeline_fetch_ras.sv - fetch-stage next-PC select with optional return-address stack (FETCH_RAS_EN)
module pipeline_fetch_ras #(
   parameter logic [31:0] RESET_VEC = 32'h80000000,
   parameter logic [31:0] IRQ_VEC   = 32'h80000004,
   parameter logic [31:0] EXC_VEC   = 32'h80000008,
   parameter int          RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [2:0]  pc_src,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic [25:0] jt,
   input  logic [31:0] reg_target,
   input  logic        fwd_valid,
   input  logic [31:0] fwd_pc,
   input  logic        call_push,
   input  logic [31:0] push_addr,
   input  logic        ret_pop,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [4:0]  ras_count,
   output logic        ras_ovf,
   output logic        ras_unf
);

   logic [31:0] pc_q, pc_d;
   logic        ras_hit;
   logic [31:0] ras_top;

   assign pc       = pc_q;
   assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_RAS_EN
   localparam int         PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(RAS_DEPTH);

   logic [31:0]   ras_mem_q [RAS_DEPTH];
   logic [PW-1:0] top_q, top_d;
   logic [4:0]    count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          ras_we;
   logic [PW-1:0] ras_wr_idx;
   logic          ras_act;

   // Stalls and interrupt/exception redirects leave the stack untouched.
   assign ras_act   = !stall && (pc_src != 3'd4) && (pc_src != 3'd5);
   assign ras_top   = ras_mem_q[top_q];
   assign ras_hit   = ret_pop && (count_q != 5'd0) && !fwd_valid;
   assign ras_count = count_q;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;

   // Stack pointer/count update; push+pop on a non-empty stack rewrites the top in place.
   always_comb begin
      top_d      = top_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      ras_we     = 1'b0;
      ras_wr_idx = top_q;
      if (ras_act) begin
         if (call_push && ret_pop && (count_q != 5'd0)) begin
            ras_we     = 1'b1;
            ras_wr_idx = top_q;
         end else if (call_push) begin
            ras_we     = 1'b1;
            ras_wr_idx = top_q + PW'(1);
            top_d      = top_q + PW'(1);
            if (count_q == DEPTH_C) begin
               ovf_d = 1'b1;
            end else begin
               count_d = count_q + 5'd1;
            end
         end else if (ret_pop) begin
            if (count_q != 5'd0) begin
               top_d   = top_q - PW'(1);
               count_d = count_q - 5'd1;
            end else begin
               unf_d = 1'b1;
            end
         end
      end
   end

   // Stack control registers; reset drops any operation presented in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         top_q   <= '0;
         count_q <= 5'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && ras_we) begin
         ras_mem_q[ras_wr_idx] <= push_addr;
      end
   end
`else
   logic unused_ras;

   assign unused_ras = ^{call_push, push_addr, ret_pop};
   assign ras_hit    = 1'b0;
   assign ras_top    = 32'd0;
   assign ras_count  = 5'd0;
   assign ras_ovf    = 1'b0;
   assign ras_unf    = 1'b0;
`endif

   // Next-PC priority: interrupt beats stall; forwarded PC beats register jump and exception.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (pc_src == 3'd4) begin
         pc_d = IRQ_VEC;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (pc_src == 3'd0) begin
         pc_d = pc_q + 32'd4;
      end else if ((pc_src == 3'd1) && br_taken) begin
         pc_d = br_target;
      end else if (pc_src == 3'd2) begin
         pc_d = {pc_q[31:28], jt, 2'b00};
      end else if (fwd_valid) begin
         pc_d = {1'b0, fwd_pc[30:0]};
      end else if (pc_src == 3'd3) begin
         pc_d = ras_hit ? ras_top : reg_target;
      end else if (pc_src == 3'd5) begin
         pc_d = EXC_VEC;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_VEC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule
